alu_ctrl_mc: RTL

Parametrised, registered successor to the single-cycle ALU control decoder in the RISC-V CPU. It decodes ALUOp plus funct3/funct7 for R-type and I-type instructions into an ALU control code, and sequences multi-cycle MUL/DIV operations with a ready/valid handshake. It sits between the ID/EX pipeline register and the ALU/MDU, and raises busy_o to the hazard unit while a long operation runs.

---
 rtl/alu_ctrl_pkg.sv | 53 +++++
 rtl/alu_ctrl_mc_if.sv | 23 ++
 rtl/alu_ctrl_decode.sv | 68 ++++++
 rtl/alu_ctrl_mc.sv | 115 +++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU control codes, decode constants and FSM types
// Shared by alu_ctrl_decode and alu_ctrl_mc.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_XOR     = 4'b0011;
    localparam logic [3:0] ALU_SLL     = 4'b0100;
    localparam logic [3:0] ALU_SRL     = 4'b0101;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_MUL     = 4'b0111;
    localparam logic [3:0] ALU_SRA     = 4'b1000;
    localparam logic [3:0] ALU_SLT     = 4'b1001;
    localparam logic [3:0] ALU_SLTU    = 4'b1010;
    localparam logic [3:0] ALU_DIV     = 4'b1011;
    localparam logic [3:0] ALU_REM     = 4'b1100;
    localparam logic [3:0] ALU_DIVU    = 4'b1101;
    localparam logic [3:0] ALU_REMU    = 4'b1110;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_R      = 2'b10;
    localparam logic [1:0] ALUOP_I      = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam int CNT_W = $clog2(256);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_multi(input logic [3:0] code);
        return (code == ALU_MUL) || (code == ALU_DIV) || (code == ALU_DIVU) ||
               (code == ALU_REM) || (code == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_ctrl_mc_if.sv
// rtl/alu_ctrl_mc_if.sv - request/response bundle between ID/EX and the ALU control sequencer
interface alu_ctrl_mc_if #(parameter int CTRL_W = 4);
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [31:0]       inst_i;
    logic [1:0]        ALUOp_i;
    logic [CTRL_W-1:0] ALUCtrl_o;
    logic              valid_o;
    logic              out_ready_i;
    logic              busy_o;
    logic              illegal_o;

    modport master (
        output flush_i, valid_i, inst_i, ALUOp_i, out_ready_i,
        input  ready_o, ALUCtrl_o, valid_o, busy_o, illegal_o
    );

    modport slave (
        input  flush_i, valid_i, inst_i, ALUOp_i, out_ready_i,
        output ready_o, ALUCtrl_o, valid_o, busy_o, illegal_o
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALUOp/funct3/funct7 decode to ALU control code
// MUL/DIV decode is present only when ALU_CTRL_MDU_EN is defined.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] code,
    output logic       illegal,
    output logic       multi
);

    function automatic logic [3:0] base_code(input logic [2:0] f3);
        case (f3)
            F3_ADD:  return ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        code = ALU_ILLEGAL;
        case (alu_op)
            ALUOP_MEM:    code = ALU_ADD;
            ALUOP_BRANCH: code = ALU_SUB;
            ALUOP_R: begin
                case (funct7)
                    F7_BASE: code = base_code(funct3);
                    F7_ALT: begin
                        if (funct3 == F3_ADD)     code = ALU_SUB;
                        else if (funct3 == F3_SR) code = ALU_SRA;
                    end
`ifdef ALU_CTRL_MDU_EN
                    F7_MULDIV: begin
                        case (funct3)
                            3'b000:  code = ALU_MUL;
                            3'b100:  code = ALU_DIV;
                            3'b101:  code = ALU_DIVU;
                            3'b110:  code = ALU_REM;
                            3'b111:  code = ALU_REMU;
                            default: code = ALU_ILLEGAL;
                        endcase
                    end
`endif
                    default: code = ALU_ILLEGAL;
                endcase
            end
            default: begin
                // Immediates carry no funct7; only the shift forms reuse those bits.
                code = base_code(funct3);
                if (funct3 == F3_SR && funct7[5])
                    code = ALU_SRA;
                if (funct3 == F3_SLL && funct7 != F7_BASE)
                    code = ALU_ILLEGAL;
            end
        endcase
    end

    assign illegal = (code == ALU_ILLEGAL);
    assign multi   = is_multi(code);

endmodule

// File: rtl/alu_ctrl_mc.sv
// rtl/alu_ctrl_mc.sv - registered ALU control decode with multi-cycle MUL/DIV sequencing
// Optional MUL/DIV support is enabled by defining ALU_CTRL_MDU_EN.
module alu_ctrl_mc
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_ctrl_mc_if.slave  bus
);

    localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV_LAT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       code_q, code_nxt;
    logic             ill_q, ill_nxt;
    logic [3:0]       dec_code;
    logic             dec_ill, dec_multi;
    logic [CNT_W-1:0] load_m1;
    logic             take;
    logic             ready_int;
    logic             unused_inst;

    assign unused_inst = ^{bus.inst_i[24:15], bus.inst_i[11:0]};

    alu_ctrl_decode u_decode (
        .alu_op  (bus.ALUOp_i),
        .funct3  (bus.inst_i[14:12]),
        .funct7  (bus.inst_i[31:25]),
        .code    (dec_code),
        .illegal (dec_ill),
        .multi   (dec_multi)
    );

    assign load_m1 = (dec_code == ALU_MUL) ? MUL_M1 : DIV_M1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        code_nxt  = code_q;
        ill_nxt   = ill_q;
        take      = 1'b0;
        ready_int = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_int = 1'b1;
                take      = bus.valid_i;
            end
            ST_BUSY: begin
                // BUSY lasts LAT-1 cycles so valid_o is seen LAT edges after acceptance.
                cnt_nxt = cnt - 1'b1;
                if (cnt == CNT_W'(1))
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                ready_int = bus.out_ready_i;
                if (bus.out_ready_i) begin
                    if (bus.valid_i) take = 1'b1;
                    else             state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (take) begin
            code_nxt = dec_code;
            ill_nxt  = dec_ill;
            if (dec_multi && load_m1 != '0) begin
                state_nxt = ST_BUSY;
                cnt_nxt   = load_m1;
            end else begin
                state_nxt = ST_DONE;
                cnt_nxt   = '0;
            end
        end

        if (bus.flush_i) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            code_nxt  = code_q;
            ill_nxt   = ill_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            code_q <= '0;
            ill_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            code_q <= code_nxt;
            ill_q  <= ill_nxt;
        end
    end

    // ready_o is held low while reset is applied so every output reads zero.
    assign bus.ready_o   = rst_i && ready_int;
    assign bus.valid_o   = (state == ST_DONE);
    assign bus.ALUCtrl_o = CTRL_W'(code_q);
    assign bus.illegal_o = ill_q && (state == ST_DONE);
`ifdef ALU_CTRL_MDU_EN
    assign bus.busy_o    = (state == ST_BUSY);
`else
    assign bus.busy_o    = 1'b0;
`endif

endmodule
